kicker_gate_pattern_generator: RTL and testbench



---
 rtl/kicker_gate_pattern_generator_if.sv | 29 ++
 rtl/kicker_gate_pattern_generator.sv | 142 ++++++++++++++
 tb/tb_kicker_gate_pattern_generator.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/kicker_gate_pattern_generator_if.sv
// Kicker gate pattern generator bus: trigger, configuration and SERDES word outputs.
//   master : drives kgdGateStrobe and the cfg* load; observes data, busy and the counters
//   slave  : the generator itself
interface kicker_gate_pattern_generator_if #(
  parameter int unsigned SERDES_WIDTH      = 8,
  parameter int unsigned OFFSET_WIDTH      = 12,
  parameter int unsigned PULSE_WIDTH_WIDTH = 12,
  parameter int unsigned COUNT_WIDTH       = 16
);
  logic                         kgdGateStrobe;
  logic                         cfgStrobe;
  logic                         cfgEnable;
  logic [OFFSET_WIDTH-1:0]      cfgOffset;
  logic [PULSE_WIDTH_WIDTH-1:0] cfgWidth;
  logic [SERDES_WIDTH-1:0]      kgdSerdesData;
  logic                         busy;
  logic [COUNT_WIDTH-1:0]       triggerCount;
  logic [COUNT_WIDTH-1:0]       overrunCount;

  modport master (
    output kgdGateStrobe, cfgStrobe, cfgEnable, cfgOffset, cfgWidth,
    input  kgdSerdesData, busy, triggerCount, overrunCount
  );

  modport slave (
    input  kgdGateStrobe, cfgStrobe, cfgEnable, cfgOffset, cfgWidth,
    output kgdSerdesData, busy, triggerCount, overrunCount
  );
endinterface

// File: rtl/kicker_gate_pattern_generator.sv
// Kicker gate pattern generator: on each delayed gate strobe, emits a gate pulse
// with bit-period start offset and width as a stream of SERDES_WIDTH-bit words
// (bit 0 sent first) for the kicker output OSERDES.
// Ports:
//   kgdClk   : byte clock, sole clock
//   kgdReset : synchronous active-high reset
//   bus      : slave side of kicker_gate_pattern_generator_if (strobe, config load,
//              kgdSerdesData, busy, triggerCount, overrunCount); all outputs registered
module kicker_gate_pattern_generator #(
  parameter int unsigned SERDES_WIDTH      = 8,
  parameter int unsigned OFFSET_WIDTH      = 12,
  parameter int unsigned PULSE_WIDTH_WIDTH = 12,
  parameter int unsigned COUNT_WIDTH       = 16
) (
  input  logic                                  kgdClk,
  input  logic                                  kgdReset,
  kicker_gate_pattern_generator_if.slave        bus
);
  localparam int unsigned SHIFT_W = $clog2(SERDES_WIDTH);
  localparam int unsigned END_W   = OFFSET_WIDTH + 1;
  localparam int unsigned K_W     = END_W - SHIFT_W + 1;
  localparam int unsigned POS_W   = K_W + SHIFT_W;

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

  state_e                       state_q, state_d;
  logic [K_W-1:0]               k_q, k_d;
  logic                         pend_en_q, pend_en_d;
  logic [OFFSET_WIDTH-1:0]      pend_off_q, pend_off_d;
  logic [PULSE_WIDTH_WIDTH-1:0] pend_wid_q, pend_wid_d;
  logic                         sh_en_q, sh_en_d;
  logic [OFFSET_WIDTH-1:0]      sh_off_q, sh_off_d;
  logic [PULSE_WIDTH_WIDTH-1:0] sh_wid_q, sh_wid_d;
  logic [SERDES_WIDTH-1:0]      data_q, data_d;
  logic                         busy_q, busy_d;
  logic [COUNT_WIDTH-1:0]       trig_cnt_q, trig_cnt_d;
  logic [COUNT_WIDTH-1:0]       ovr_cnt_q, ovr_cnt_d;

  logic [END_W-1:0]             pulse_end_c;
  logic [K_W-1:0]               word_k_c;
  logic                         emit_c;
  logic [POS_W-1:0]             bit_pos_c;

  // Next-state, shadow config and output word computation
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    pend_en_d  = bus.cfgStrobe ? bus.cfgEnable : pend_en_q;
    pend_off_d = bus.cfgStrobe ? bus.cfgOffset : pend_off_q;
    pend_wid_d = bus.cfgStrobe ? bus.cfgWidth  : pend_wid_q;
    sh_en_d    = sh_en_q;
    sh_off_d   = sh_off_q;
    sh_wid_d   = sh_wid_q;
    data_d     = '0;
    busy_d     = 1'b0;
    trig_cnt_d = trig_cnt_q;
    ovr_cnt_d  = ovr_cnt_q;
    word_k_c   = '0;
    emit_c     = 1'b0;
    bit_pos_c  = '0;

    pulse_end_c = END_W'(sh_off_q) + END_W'(sh_wid_q);

    unique case (state_q)
      ST_IDLE: begin
        // Zero-width triggers are counted but produce no words
        if (bus.kgdGateStrobe && sh_en_q) begin
          trig_cnt_d = trig_cnt_q + COUNT_WIDTH'(1);
          if (sh_wid_q != '0) begin
            emit_c  = 1'b1;
            state_d = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: begin
        if (bus.kgdGateStrobe) ovr_cnt_d = ovr_cnt_q + COUNT_WIDTH'(1);
        // k_q is the next word index; once it starts at or past the end, the
        // word currently on the output was the last one
        if ((POS_W'(k_q) << SHIFT_W) >= POS_W'(pulse_end_c)) begin
          state_d = ST_IDLE;
        end else begin
          emit_c   = 1'b1;
          word_k_c = k_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit_c) begin
      k_d    = word_k_c + K_W'(1);
      busy_d = 1'b1;
      for (int i = 0; i < int'(SERDES_WIDTH); i++) begin
        bit_pos_c = (POS_W'(word_k_c) << SHIFT_W) + POS_W'(i);
        data_d[i] = (bit_pos_c >= POS_W'(sh_off_q)) && (bit_pos_c < POS_W'(pulse_end_c));
      end
    end

    // Pending config reaches the shadow only while idle; an accepted trigger
    // keeps the old shape until the pulse completes
    if (state_d == ST_IDLE) begin
      sh_en_d  = pend_en_d;
      sh_off_d = pend_off_d;
      sh_wid_d = pend_wid_d;
    end
  end

  // State and output registers
  always_ff @(posedge kgdClk) begin
    if (kgdReset) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      pend_en_q  <= 1'b0;
      pend_off_q <= '0;
      pend_wid_q <= '0;
      sh_en_q    <= 1'b0;
      sh_off_q   <= '0;
      sh_wid_q   <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      trig_cnt_q <= '0;
      ovr_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      pend_en_q  <= pend_en_d;
      pend_off_q <= pend_off_d;
      pend_wid_q <= pend_wid_d;
      sh_en_q    <= sh_en_d;
      sh_off_q   <= sh_off_d;
      sh_wid_q   <= sh_wid_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      trig_cnt_q <= trig_cnt_d;
      ovr_cnt_q  <= ovr_cnt_d;
    end
  end

  assign bus.kgdSerdesData = data_q;
  assign bus.busy          = busy_q;
  assign bus.triggerCount  = trig_cnt_q;
  assign bus.overrunCount  = ovr_cnt_q;
endmodule

// File: tb/tb_kicker_gate_pattern_generator.sv
// Bench for kicker_gate_pattern_generator: directed plan plus random traffic,
// expected words queued by a bit-level reference model, compared by a monitor.
module tb_kicker_gate_pattern_generator;
  localparam int unsigned SW = 8;
  localparam int unsigned OW = 12;
  localparam int unsigned PW = 12;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kicker_gate_pattern_generator_if #(
    .SERDES_WIDTH(SW), .OFFSET_WIDTH(OW), .PULSE_WIDTH_WIDTH(PW), .COUNT_WIDTH(CW)
  ) bus ();

  kicker_gate_pattern_generator #(
    .SERDES_WIDTH(SW), .OFFSET_WIDTH(OW), .PULSE_WIDTH_WIDTH(PW), .COUNT_WIDTH(CW)
  ) dut (
    .kgdClk   (clk),
    .kgdReset (rst),
    .bus      (bus.slave)
  );

  // Reference model state
  int              act;        // output cycles still busy, counted from the current cycle
  bit              sh_en, pd_en;
  int              sh_off, sh_wid, pd_off, pd_wid;
  int              trig, ovr;
  logic [SW-1:0]   exp_q[$];
  bit              mon_en = 1'b0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  // Queue every word of a pulse, built bit by bit from the start/end rule
  task automatic push_pulse(input int off, input int wid);
    int e, n;
    logic [SW-1:0] wd;
    e = off + wid;
    n = (e + int'(SW) - 1) / int'(SW);
    for (int w = 0; w < n; w++) begin
      wd = '0;
      for (int i = 0; i < int'(SW); i++) begin
        int p;
        p = w * int'(SW) + i;
        wd[i] = (p >= off) && (p < e);
      end
      exp_q.push_back(wd);
    end
    act = n;
  endtask

  task automatic model_step(input bit r, input bit st, input bit cs, input bit ce,
                            input int co, input int cw);
    if (r) begin
      act = 0; exp_q.delete();
      sh_en = 0; sh_off = 0; sh_wid = 0;
      pd_en = 0; pd_off = 0; pd_wid = 0;
      trig = 0; ovr = 0;
      return;
    end
    if (act > 0) begin
      if (st) ovr = (ovr + 1) % 65536;
      act--;
    end else if (st && sh_en) begin
      trig = (trig + 1) % 65536;
      if (sh_wid != 0) push_pulse(sh_off, sh_wid);
    end
    if (cs) begin pd_en = ce; pd_off = co; pd_wid = cw; end
    if (act == 0) begin sh_en = pd_en; sh_off = pd_off; sh_wid = pd_wid; end
  endtask

  task automatic cycle(input bit r, input bit st, input bit cs, input bit ce,
                       input int co, input int cw);
    @(negedge clk);
    rst               = r;
    bus.kgdGateStrobe = st;
    bus.cfgStrobe     = cs;
    bus.cfgEnable     = ce;
    bus.cfgOffset     = OW'(co);
    bus.cfgWidth      = PW'(cw);
    @(posedge clk);
    model_step(r, st, cs, ce, co, cw);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask
  task automatic cfg(input bit en, input int o, input int w);
    cycle(0, 0, 1, en, o, w);
  endtask
  task automatic trg();
    cycle(0, 1, 0, 0, 0, 0);
  endtask

  // Monitor: pops one expected word per busy cycle, checks zeros and counters otherwise
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", 32'(bus.busy), 32'(act > 0));
      if (bus.busy === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(bus.kgdSerdesData), 32'hFFFF_FFFF);
        end else begin
          chk("word", 32'(bus.kgdSerdesData), 32'(exp_q.pop_front()));
        end
      end else begin
        chk("idle_zero", 32'(bus.kgdSerdesData), 32'h0);
      end
      chk("triggerCount", 32'(bus.triggerCount), 32'(trig));
      chk("overrunCount", 32'(bus.overrunCount), 32'(ovr));
    end
  end

  initial begin
    bus.kgdGateStrobe = 1'b0;
    bus.cfgStrobe     = 1'b0;
    bus.cfgEnable     = 1'b0;
    bus.cfgOffset     = '0;
    bus.cfgWidth      = '0;
    model_step(1, 0, 0, 0, 0, 0);

    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    idle(2);

    cfg(1, 3, 5);  trg(); idle(4);
    cfg(1, 6, 4);  trg(); idle(4);
    cfg(1, 16, 8); trg(); idle(5);
    cfg(1, 0, 20); trg(); idle(5);

    // Overrun two cycles into a five-word pulse
    cfg(1, 0, 40); trg(); idle(1); trg(); idle(7);

    // Config change mid-pulse, then coincident config+trigger in idle
    trg(); idle(1); cfg(1, 0, 1); idle(6);
    trg(); idle(3);
    cycle(0, 1, 1, 1, 5, 3); idle(3);
    trg(); idle(4);

    // Reset during word 2 of a five-word pulse
    cfg(1, 0, 40); idle(1); trg(); idle(2);
    cycle(1, 0, 0, 0, 0, 0);
    idle(2);
    trg(); idle(3);
    cfg(1, 4, 0); trg(); idle(3);

    // Strobe every cycle: overrun on the last word, accept as busy falls
    cfg(1, 2, 9);
    for (int i = 0; i < 12; i++) trg();
    idle(5);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      bit r, st, cs, ce;
      int co, cw;
      r  = ($urandom % 600) == 0;
      st = ($urandom % 5) == 0;
      cs = ($urandom % 8) == 0;
      ce = ($urandom % 6) != 0;
      co = (($urandom % 60) == 0) ? int'($urandom % 4096) : int'($urandom % 40);
      cw = (($urandom % 60) == 0) ? int'($urandom % 4096) : int'($urandom % 40);
      cycle(r, st, cs, ce, co, cw);
    end

    // Drain, bounded
    for (int i = 0; i < 1200 && act > 0; i++) idle(1);
    idle(2);
    chk("drain_busy", 32'(act), 32'h0);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
